// File: rtl/arbitro_rr_pkg.sv
// arbitro_rr shared definitions: FSM state encoding and default geometry.
// Optional round-robin grant is enabled with ARBITRO_RR_EN.
package arbitro_rr_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int WORD_DEF  = 10;
    localparam int PORTS_DEF = 4;

    // Low bit of slice idx in a flattened bank of w-bit words
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/arbitro_rr_if.sv
// FIFO-bank side of arbitro_rr: input FIFO heads/pops and output FIFO pushes.
// Optional round-robin grant is enabled with ARBITRO_RR_EN.
interface arbitro_rr_if #(
    parameter int FIFO_WORD_SIZE = 10,
    parameter int NUM_PORTS      = 4
);
    logic [NUM_PORTS-1:0]                empty;
    logic [NUM_PORTS-1:0]                almostfull;
    logic [NUM_PORTS*FIFO_WORD_SIZE-1:0] data_in;
    logic [NUM_PORTS-1:0]                pop;
    logic [NUM_PORTS-1:0]                push;
    logic [NUM_PORTS*FIFO_WORD_SIZE-1:0] data_out;
    logic                                idle;

    modport master (
        output empty, almostfull, data_in,
        input  pop, push, data_out, idle
    );

    modport slave (
        input  empty, almostfull, data_in,
        output pop, push, data_out, idle
    );
endinterface

// File: rtl/arbitro_rr_picker.sv
// rr_picker: one-hot grant plus index from a request vector.
// ARBITRO_RR_EN selects round-robin after ptr; otherwise lowest index wins.
module rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
`ifdef ARBITRO_RR_EN
    input  logic [W-1:0] ptr,
`endif
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);

    logic found;

`ifdef ARBITRO_RR_EN
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        // Search starts just past the last winner and wraps
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = W'(j);
            end
        end
    end
`else
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = W'(j);
            end
        end
    end
`endif

endmodule

// File: rtl/arbitro_rr.sv
// arbitro_rr: routes one input FIFO head per cycle to its destination FIFO.
// ARBITRO_RR_EN enables round-robin fairness; default is fixed priority.
module arbitro_rr
    import arbitro_rr_pkg::*;
#(
    parameter int FIFO_WORD_SIZE = WORD_DEF,
    parameter int NUM_PORTS      = PORTS_DEF
) (
    input logic       clk,
    input logic       reset_L,
    arbitro_rr_if.slave bus
);

    localparam int FW     = FIFO_WORD_SIZE;
    localparam int DEST_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]    req;
    logic [NUM_PORTS-1:0]    gnt;
    logic [DEST_W-1:0]       gnt_idx;
    logic [DEST_W-1:0]       dest_i;
    logic [FW-1:0]           gnt_word;
    logic [DEST_W-1:0]       gnt_dest;
    logic                    any_gnt;

    logic [NUM_PORTS-1:0]    push_q;
    logic [NUM_PORTS*FW-1:0] data_q;
    state_t                  state;

    // Blocking is per destination; reset gates every request so pop drops
    always_comb begin
        req    = '0;
        dest_i = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            dest_i = bus.data_in[slice_lo(i, FW) + FW - 1 -: DEST_W];
            req[i] = reset_L && !bus.empty[i] && !bus.almostfull[dest_i];
        end
    end

`ifdef ARBITRO_RR_EN
    logic [DEST_W-1:0] ptr;

    rr_picker #(.N(NUM_PORTS), .W(DEST_W)) u_picker (
        .req (req),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (!reset_L)
            ptr <= DEST_W'(NUM_PORTS - 1);
        else if (any_gnt)
            ptr <= gnt_idx;
    end
`else
    rr_picker #(.N(NUM_PORTS), .W(DEST_W)) u_picker (
        .req (req),
        .gnt (gnt),
        .idx (gnt_idx)
    );
`endif

    assign any_gnt  = |gnt;
    assign gnt_word = bus.data_in[slice_lo(int'(gnt_idx), FW) +: FW];
    assign gnt_dest = gnt_word[FW-1 -: DEST_W];

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            push_q <= '0;
            data_q <= '0;
            state  <= IDLE;
        end else begin
            push_q <= '0;
            data_q <= '0;
            if (any_gnt) begin
                push_q[gnt_dest] <= 1'b1;
                data_q[slice_lo(int'(gnt_dest), FW) +: FW] <= gnt_word;
                state <= ACTIVE;
            end else begin
                state <= IDLE;
            end
        end
    end

    assign bus.pop      = gnt;
    assign bus.push     = push_q;
    assign bus.data_out = data_q;
    assign bus.idle     = (state == IDLE);

endmodule

// File: tb/tb_arbitro_rr.sv
// Vector table plus scoreboard bench for arbitro_rr (4 ports, 10-bit words).
// Expectations follow ARBITRO_RR_EN when defined, fixed priority otherwise.
module tb_arbitro_rr;

    localparam int FW = 10;
    localparam int NP = 4;

    logic clk = 1'b0;
    logic reset_L;

    always #5 clk = ~clk;

    arbitro_rr_if #(.FIFO_WORD_SIZE(FW), .NUM_PORTS(NP)) bus ();

    arbitro_rr #(.FIFO_WORD_SIZE(FW), .NUM_PORTS(NP)) u_dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus.slave)
    );

    typedef struct {
        logic        rst_n;
        logic [3:0]  emp;
        logic [3:0]  af;
        logic [39:0] din;
        logic [3:0]  exp_pop;
        string       nm;
    } vec_t;

    typedef struct {
        logic [3:0]  push;
        logic [39:0] data;
        logic        idle;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // port i head routed to destination 3-i
    localparam logic [39:0] DIN_RR =
        {10'h043, 10'h132, 10'h221, 10'h310};
    // port1 -> dest 2, port2 -> dest 0
    localparam logic [39:0] DIN_BLK =
        {10'h177, 10'h066, 10'h255, 10'h3AA};

    function automatic logic [39:0] din_p2(input logic [9:0] w);
        logic [39:0] d;
        d = '0;
        d[29:20] = w;
        return d;
    endfunction

    task automatic check(input string nm, input logic [39:0] act,
                         input logic [39:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Inputs applied just after a rising edge; pop checked before the next
    task automatic apply(input vec_t v);
        exp_t e;
        exp_t g;
        logic [9:0] w;
        int d;
        reset_L        = v.rst_n;
        bus.empty      = v.emp;
        bus.almostfull = v.af;
        bus.data_in    = v.din;
        #2;
        check({v.nm, " pop"}, 40'(bus.pop), 40'(v.exp_pop));
        e.push = '0;
        e.data = '0;
        e.idle = 1'b1;
        for (int i = 0; i < NP; i++) begin
            if (v.rst_n && v.exp_pop[i]) begin
                w = v.din[i*FW +: FW];
                d = int'(w[9:8]);
                e.push[d] = 1'b1;
                e.data = 40'(w) << (d * FW);
                e.idle = 1'b0;
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check({v.nm, " push"}, 40'(bus.push), 40'(g.push));
        check({v.nm, " data_out"}, bus.data_out, g.data);
        check({v.nm, " idle"}, 40'(bus.idle), 40'(g.idle));
    endtask

    initial begin
        reset_L        = 1'b0;
        bus.empty      = '1;
        bus.almostfull = '0;
        bus.data_in    = '0;

        vecs.push_back('{1'b0, 4'b0000, 4'b0000, DIN_RR, 4'b0000, "rst0"});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000, DIN_RR, 4'b0000, "rst1"});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000, DIN_RR, 4'b0000, "rst2"});
`ifdef ARBITRO_RR_EN
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, DIN_RR, 4'b0001, "rr0"});
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, DIN_RR, 4'b0010, "rr1"});
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, DIN_RR, 4'b0100, "rr2"});
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, DIN_RR, 4'b1000, "rr3"});
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, DIN_RR, 4'b0001, "rr4"});
`else
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, DIN_RR, 4'b0001, "fp0"});
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, DIN_RR, 4'b0001, "fp1"});
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, DIN_RR, 4'b0001, "fp2"});
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, DIN_RR, 4'b0001, "fp3"});
        vecs.push_back('{1'b1, 4'b0000, 4'b0000, DIN_RR, 4'b0001, "fp4"});
`endif
        vecs.push_back('{1'b1, 4'b1001, 4'b0100, DIN_BLK, 4'b0100, "blk"});
        vecs.push_back('{1'b1, 4'b1111, 4'b0000, DIN_BLK, 4'b0000, "empty"});
        vecs.push_back('{1'b1, 4'b1011, 4'b0000, din_p2(10'h101), 4'b0100, "drain0"});
        vecs.push_back('{1'b1, 4'b1011, 4'b0000, din_p2(10'h102), 4'b0100, "drain1"});
        vecs.push_back('{1'b1, 4'b1011, 4'b0000, din_p2(10'h103), 4'b0100, "drain2"});
        vecs.push_back('{1'b1, 4'b1111, 4'b0000, din_p2(10'h103), 4'b0000, "drain_idle"});
`ifdef ARBITRO_RR_EN
        vecs.push_back('{1'b1, 4'b0000, 4'b1000, DIN_RR, 4'b1000, "af_dest3"});
`else
        vecs.push_back('{1'b1, 4'b0000, 4'b1000, DIN_RR, 4'b0010, "af_dest3"});
`endif
        vecs.push_back('{1'b1, 4'b0000, 4'b1111, DIN_RR, 4'b0000, "all_blk"});
        vecs.push_back('{1'b1, 4'b1110, 4'b0000, 40'h0_0000_02A5, 4'b0001, "pre_rst"});

        @(posedge clk);
        #1;
        foreach (vecs[i]) apply(vecs[i]);

        // Word popped here is pending in the output register when reset hits
        bus.empty   = 4'b1110;
        bus.data_in = 40'h0_0000_02A5;
        reset_L     = 1'b1;
        #2;
        check("mid pop", 40'(bus.pop), 40'h1);
        @(posedge clk);
        #1;
        reset_L = 1'b0;
        #2;
        check("mid pop gated", 40'(bus.pop), 40'h0);
        @(posedge clk);
        #1;
        check("mid push", 40'(bus.push), 40'h0);
        check("mid data_out", bus.data_out, 40'h0);
        check("mid idle", 40'(bus.idle), 40'h1);

        // Release: port 0 must be first served
        bus.empty   = 4'b0000;
        bus.data_in = DIN_RR;
        reset_L     = 1'b1;
        #2;
        check("post_rst pop", 40'(bus.pop), 40'h1);
        @(posedge clk);
        #1;
        check("post_rst push", 40'(bus.push), 40'h8);
        check("post_rst data_out", bus.data_out, 40'h310 << 30);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
